// File: rtl/input_accum_pkg.sv
// Shared field positions and helpers for the input accumulator.
// Build with INPUT_ACCUM_CLAMP_EN to saturate the accumulators instead of wrapping.
package input_accum_pkg;

    localparam int SPIN_W    = 9;
    localparam int MS_TOGGLE = 24;
    localparam int MS_Y_HI   = 23;
    localparam int MS_X_HI   = 15;
    localparam int MS_XSIGN  = 4;
    localparam int MS_YSIGN  = 5;

    // Widest position supported; callers cast the result down to POS_W.
    localparam int POS_W_MAX = 32;

    function automatic logic [POS_W_MAX-1:0] sext9_to_pos(input logic [8:0] v);
        return {{(POS_W_MAX-9){v[8]}}, v};
    endfunction

endpackage

// File: rtl/input_accum_chan.sv
// One motion channel: toggle-flag event detect, signed accumulator, per-frame snapshot.
// INPUT_ACCUM_CLAMP_EN selects saturating accumulation at the signed limits.
module input_accum_chan
#(
    parameter int POS_W = 16
)(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             toggle,
    input  logic [POS_W-1:0] delta,
    input  logic             clear,
    input  logic             snap,
    output logic [POS_W-1:0] pos
);

    logic             tog_q;
    logic             evt;
    logic [POS_W-1:0] acc;
    logic [POS_W-1:0] acc_nxt;

    assign evt = toggle ^ tog_q;

`ifdef INPUT_ACCUM_CLAMP_EN
    logic [POS_W-1:0] sum;
    logic             ovf;

    assign sum = acc + delta;
    // Overflow only when both operands share a sign and the result flips it.
    assign ovf = (acc[POS_W-1] == delta[POS_W-1]) && (sum[POS_W-1] != acc[POS_W-1]);

    always_comb begin
        acc_nxt = sum;
        if (ovf)
            acc_nxt = delta[POS_W-1] ? {1'b1, {(POS_W-1){1'b0}}} : {1'b0, {(POS_W-1){1'b1}}};
    end
`else
    assign acc_nxt = acc + delta;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tog_q <= toggle;
            acc   <= '0;
            pos   <= '0;
        end else begin
            tog_q <= toggle;
            if (clear)
                acc <= '0;
            else if (evt)
                acc <= acc_nxt;
            // Snapshot takes the pre-update accumulator, so a same-cycle event lands next frame.
            if (clear)
                pos <= '0;
            else if (snap)
                pos <= acc;
        end
    end

endmodule

// File: rtl/input_accum.sv
// Spinner and PS/2 mouse relative-to-absolute position accumulation with VBlank snapshots.
// Optional saturation instead of wrap is enabled by defining INPUT_ACCUM_CLAMP_EN.
module input_accum
    import input_accum_pkg::*;
#(
    parameter int CHANNELS = 6,
    parameter int POS_W    = 16
)(
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [CHANNELS*SPIN_W-1:0] spinner,
    input  logic [24:0]               ps2_mouse,
    input  logic                      vblank,
    input  logic                      clear,
    output logic [CHANNELS*POS_W-1:0] spinner_pos,
    output logic [POS_W-1:0]          mouse_x,
    output logic [POS_W-1:0]          mouse_y,
    output logic [2:0]                mouse_btn,
    output logic [7:0]                mouse_events,
    output logic                      frame_strobe
);

    logic       vblank_q;
    logic       vb_rise;
    logic       ms_tog_q;
    logic       ms_evt;
    logic [8:0] ms_dx;
    logic [8:0] ms_dy;
    logic       unused_ok;

    assign vb_rise = vblank & ~vblank_q;
    assign ms_evt  = ps2_mouse[MS_TOGGLE] ^ ms_tog_q;
    assign ms_dx   = {ps2_mouse[MS_XSIGN], ps2_mouse[MS_X_HI -: 8]};
    assign ms_dy   = {ps2_mouse[MS_YSIGN], ps2_mouse[MS_Y_HI -: 8]};
    assign unused_ok = &{1'b0, ps2_mouse[7:6], ps2_mouse[3]};

    for (genvar n = 0; n < CHANNELS; n++) begin : g_spin
        input_accum_chan #(.POS_W(POS_W)) u_chan (
            .clk_sys (clk_sys),
            .reset   (reset),
            .toggle  (spinner[SPIN_W*n+8]),
            .delta   (POS_W'(sext9_to_pos({spinner[SPIN_W*n+7], spinner[SPIN_W*n +: 8]}))),
            .clear   (clear),
            .snap    (vb_rise),
            .pos     (spinner_pos[POS_W*n +: POS_W])
        );
    end

    input_accum_chan #(.POS_W(POS_W)) u_mouse_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .toggle  (ps2_mouse[MS_TOGGLE]),
        .delta   (POS_W'(sext9_to_pos(ms_dx))),
        .clear   (clear),
        .snap    (vb_rise),
        .pos     (mouse_x)
    );

    // PS/2 Y grows upward; negate so screen-down is positive.
    input_accum_chan #(.POS_W(POS_W)) u_mouse_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .toggle  (ps2_mouse[MS_TOGGLE]),
        .delta   (POS_W'(-sext9_to_pos(ms_dy))),
        .clear   (clear),
        .snap    (vb_rise),
        .pos     (mouse_y)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vblank_q     <= 1'b1;
            frame_strobe <= 1'b0;
            ms_tog_q     <= ps2_mouse[MS_TOGGLE];
            mouse_btn    <= '0;
            mouse_events <= '0;
        end else begin
            vblank_q     <= vblank;
            frame_strobe <= vb_rise;
            ms_tog_q     <= ps2_mouse[MS_TOGGLE];
            if (clear) begin
                mouse_events <= '0;
            end else if (ms_evt) begin
                mouse_events <= mouse_events + 8'd1;
                mouse_btn    <= ps2_mouse[2:0];
            end
        end
    end

endmodule

// File: tb/tb_input_accum.sv
// Randomised and directed checks of input_accum against a position-arithmetic model.
module tb_input_accum;

    localparam int CH = 6;
    localparam int PW = 16;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [CH*9-1:0] spinner;
    logic [24:0]     ps2_mouse;
    logic            vblank;
    logic            clear;
    logic [CH*PW-1:0] spinner_pos;
    logic [PW-1:0]   mouse_x;
    logic [PW-1:0]   mouse_y;
    logic [2:0]      mouse_btn;
    logic [7:0]      mouse_events;
    logic            frame_strobe;

    input_accum #(.CHANNELS(CH), .POS_W(PW)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .spinner      (spinner),
        .ps2_mouse    (ps2_mouse),
        .vblank       (vblank),
        .clear        (clear),
        .spinner_pos  (spinner_pos),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_btn    (mouse_btn),
        .mouse_events (mouse_events),
        .frame_strobe (frame_strobe)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;

    // toggle levels the bench is driving
    bit [CH-1:0] stog;
    bit          mtog;

    // model state
    int unsigned m_acc [CH];
    int unsigned m_snap[CH];
    int unsigned m_x, m_y, m_sx, m_sy;
    int unsigned m_btn, m_ev;
    bit          m_strobe, m_vbq;

    // stimulus for the next cycle
    bit [CH-1:0] p_ev;
    logic [7:0]  p_d[CH];
    bit          p_mev;
    logic [7:0]  p_st, p_mx, p_my;
    bit          p_clr;

    function automatic int unsigned upd(int unsigned a, int d);
        int s;
        s = (a >= 32768) ? int'(a) - 65536 : int'(a);
        s = s + d;
`ifdef INPUT_ACCUM_CLAMP_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s & 32'hFFFF;
    endfunction

    function automatic int s8(logic [7:0] v, bit neg);
        return neg ? int'(v) - 256 : int'(v);
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [CH*PW-1:0] e;
        for (int n = 0; n < CH; n++) e[n*PW +: PW] = m_snap[n][PW-1:0];
        chk("spinner_pos", 128'(spinner_pos), 128'(e));
        chk("mouse_x", 128'(mouse_x), 128'(m_sx[PW-1:0]));
        chk("mouse_y", 128'(mouse_y), 128'(m_sy[PW-1:0]));
        chk("mouse_btn", 128'(mouse_btn), 128'(m_btn[2:0]));
        chk("mouse_events", 128'(mouse_events), 128'(m_ev[7:0]));
        chk("frame_strobe", 128'(frame_strobe), 128'(m_strobe));
    endtask

    task automatic drive();
        for (int n = 0; n < CH; n++) begin
            if (p_ev[n]) stog[n] = ~stog[n];
            spinner[n*9 +: 9] = {stog[n], p_d[n]};
        end
        if (p_mev) mtog = ~mtog;
        ps2_mouse = {mtog, p_my, p_mx, p_st};
        clear = p_clr;
    endtask

    task automatic model_reset();
        for (int n = 0; n < CH; n++) begin m_acc[n] = 0; m_snap[n] = 0; end
        m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_btn = 0; m_ev = 0;
        m_strobe = 0; m_vbq = 1;
    endtask

    task automatic idle();
        p_ev = '0; p_mev = 0; p_clr = 0;
    endtask

    // One clock: apply pending stimulus, advance the model, check outputs.
    task automatic cycle();
        bit vb_rise;
        drive();
        @(posedge clk_sys);
        vb_rise  = vblank && !m_vbq;
        m_vbq    = vblank;
        m_strobe = vb_rise;
        if (p_clr) begin
            for (int n = 0; n < CH; n++) begin m_acc[n] = 0; m_snap[n] = 0; end
            m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_ev = 0;
        end else begin
            if (vb_rise) begin
                for (int n = 0; n < CH; n++) m_snap[n] = m_acc[n];
                m_sx = m_x; m_sy = m_y;
            end
            for (int n = 0; n < CH; n++)
                if (p_ev[n]) m_acc[n] = upd(m_acc[n], s8(p_d[n], p_d[n][7]));
            if (p_mev) begin
                m_x   = upd(m_x, s8(p_mx, p_st[4]));
                m_y   = upd(m_y, -s8(p_my, p_st[5]));
                m_btn = p_st[2:0];
                m_ev  = (m_ev + 1) & 8'hFF;
            end
        end
        #1;
        check_all();
        idle();
    endtask

    task automatic frame();
        vblank = 0; cycle();
        vblank = 1; cycle();
        cycle();
    endtask

    task automatic do_reset();
        reset = 1;
        drive();
        @(posedge clk_sys);
        @(posedge clk_sys);
        model_reset();
        #1;
        check_all();
        reset = 0;
    endtask

    initial begin
        stog = '1; mtog = 1;
        for (int n = 0; n < CH; n++) p_d[n] = 8'h00;
        p_st = 0; p_mx = 0; p_my = 0;
        idle();
        vblank = 1;
        model_reset();

        // reset with toggles held high: no events on release
        do_reset();
        cycle(); cycle();
        frame();

        // channel 2: three +5 reports
        for (int k = 0; k < 3; k++) begin p_ev[2] = 1; p_d[2] = 8'h05; cycle(); end
        frame();
        chk("ch2_direct", 128'(spinner_pos[2*PW +: PW]), 128'(16'h000F));

        // channel 0 wraps below zero
        p_ev[0] = 1; p_d[0] = 8'hFF; cycle();
        frame();
        chk("ch0_wrap", 128'(spinner_pos[0 +: PW]), 128'(16'hFFFF));

        // channel 1 driven to 0x7FFE, then two +1: wraps or saturates
        for (int k = 0; k < 258; k++) begin p_ev[1] = 1; p_d[1] = 8'h7F; cycle(); end
        for (int k = 0; k < 2; k++) begin p_ev[1] = 1; p_d[1] = 8'h01; cycle(); end
        frame();
`ifdef INPUT_ACCUM_CLAMP_EN
        chk("ch1_limit", 128'(spinner_pos[PW +: PW]), 128'(16'h7FFF));
`else
        chk("ch1_limit", 128'(spinner_pos[PW +: PW]), 128'(16'h8000));
`endif

        // mouse report
        p_clr = 1; cycle();
        p_mev = 1; p_st = 8'h11; p_mx = 8'hF0; p_my = 8'h10; cycle();
        frame();
        chk("mouse_x_dir", 128'(mouse_x), 128'(16'hFFF0));
        chk("mouse_y_dir", 128'(mouse_y), 128'(16'hFFF0));
        chk("mouse_btn_dir", 128'(mouse_btn), 128'(3'b001));
        chk("mouse_ev_dir", 128'(mouse_events), 128'(8'd1));

        // event coincident with vb_rise goes to the next frame
        vblank = 0; cycle();
        vblank = 1; p_ev[3] = 1; p_d[3] = 8'h21; cycle();
        chk("vb_coincident_excl", 128'(spinner_pos[3*PW +: PW]), 128'(16'h0000));
        frame();
        chk("vb_coincident_next", 128'(spinner_pos[3*PW +: PW]), 128'(16'h0021));

        // clear + event + vb_rise together
        vblank = 0; cycle();
        vblank = 1; p_clr = 1; p_ev[4] = 1; p_d[4] = 8'h09; cycle();
        chk("clr_strobe", 128'(frame_strobe), 128'(1'b1));
        chk("clr_pos", 128'(spinner_pos), 128'(0));
        frame();

        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            vblank = (i % 37) >= 30;
            for (int n = 0; n < CH; n++) begin
                p_ev[n] = ($urandom_range(0, 2) == 0);
                p_d[n]  = 8'($urandom);
            end
            p_mev = ($urandom_range(0, 3) == 0);
            p_st = 8'($urandom); p_mx = 8'($urandom); p_my = 8'($urandom);
            p_clr = !p_mev && ($urandom_range(0, 59) == 0);
            cycle();
        end

        // reset mid-frame drops accumulated motion
        p_ev = '1; for (int n = 0; n < CH; n++) p_d[n] = 8'h11;
        cycle();
        idle();
        do_reset();
        frame();
        chk("reset_midframe", 128'(spinner_pos), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_accum.md
Name: input_accum

Overview:
- Sits between hps_io and the system block.
- Converts relative spinner and PS/2 mouse motion reports, which are toggle-flagged deltas, into absolute wrapping position counters.
- Snapshots the counters once per frame on VBlank rising edge, so the CPU reads stable, coherent values for a whole frame.
- Provides CPU-driven clear of all positions.

Parameters:
- CHANNELS, 6, number of spinner channels (one per player).
- POS_W, 16, width of every position accumulator and output, in bits.

Ports:
- clk_sys  in  1  system clock (24 MHz); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- spinner  in  CHANNELS*9  per channel n, slice [9n+8:9n]: bit 8 toggles per report; bits 7:0 are a signed delta.
- ps2_mouse  in  25  bit 24 toggles per report; [23:16] Y magnitude; [15:8] X magnitude; [7:0] status byte (bit4 X sign, bit5 Y sign, bits2:0 buttons L/R/M).
- vblank  in  1  video vertical blank, clk_sys domain.
- clear  in  1  single-cycle pulse from CPU; zeroes all positions.
- spinner_pos  out  CHANNELS*POS_W  snapshot position of channel n at [POS_W*n+POS_W-1:POS_W*n].
- mouse_x  out  POS_W  snapshot X position.
- mouse_y  out  POS_W  snapshot Y position; screen-down is positive.
- mouse_btn  out  3  live buttons, registered from the last mouse report.
- mouse_events  out  8  count of mouse reports, wrapping.
- frame_strobe  out  1  one-cycle pulse in the cycle the snapshot outputs change.

Behaviour:
- Reset values:
  - All accumulators, outputs, mouse_events and frame_strobe are 0.
  - Previous-toggle registers load the current input toggle bits, so leaving reset never creates a spurious event.
  - vblank edge register loads 1, so a reset released during VBlank produces no snapshot.
- Event detection: an event occurs when the input toggle bit differs from the registered previous toggle. The previous toggle updates every cycle.
- Event latency: the accumulator holds the new value 1 cycle after the cycle in which the toggle changed.
- Spinner accumulation: acc_n <= acc_n + sign_extend(delta[7:0], POS_W), modulo 2^POS_W.
- Mouse deltas and accumulation:
  - dx = {status[4], X[7:0]}, dy = {status[5], Y[7:0]}, both 9-bit two's complement, sign-extended to POS_W.
  - acc_x <= acc_x + dx.
  - acc_y <= acc_y - dy, because PS/2 Y is positive-up.
  - mouse_btn <= status[2:0].
  - mouse_events increments by 1.
- Wrap-around: 0xFFFF + 1 = 0x0000 and 0x0000 - 1 = 0xFFFF (POS_W=16).
- Snapshot:
  - vb_rise = vblank & ~vblank_q.
  - In the cycle after vb_rise, outputs hold the accumulator values as they were in the vb_rise cycle, and frame_strobe = 1.
  - An event in the vb_rise cycle is excluded from this snapshot but is applied to the accumulator; it appears in the next frame's snapshot.
- Clear:
  - The next cycle, all accumulators and snapshot outputs are 0 and mouse_events = 0. mouse_btn is unaffected.
  - clear takes priority over a simultaneous event (the event is discarded) and over a simultaneous vb_rise (outputs become 0, frame_strobe still pulses).
- Multiple channels may have events in the same cycle; each is applied independently.
- Reset mid-frame discards all accumulated motion.

Optional Feature:
- Macro: INPUT_ACCUM_CLAMP_EN.
- Defined: accumulators saturate at signed limits, 0x7FFF and 0x8000 for POS_W=16. An update that would overflow holds the limit. Clear still zeroes.
- Undefined: modulo wrap as described in Behaviour; no saturation logic is synthesised.

Decomposition:
- Package input_accum_pkg holds:
  - Mouse field-position localparams: MS_TOGGLE=24, MS_Y_HI=23, MS_X_HI=15, MS_XSIGN=4, MS_YSIGN=5.
  - SPIN_W=9.
  - A function sext9_to_pos for sign extension to POS_W.
- Sub-module input_accum_chan is the natural split: one toggle detector, one signed accumulator, one snapshot register, with clear and clamp logic.
  - Instantiated CHANNELS times for the spinners and twice for mouse X/Y; Y is fed the negated delta.

Test Plan:
- Reset release with spinner[8]=1 held: no accumulator change; spinner_pos=0 after the next vb_rise.
- Channel 2 toggle with delta 0x05 three times, then vb_rise: spinner_pos[2]=0x000F, frame_strobe pulses exactly 1 cycle, other channels 0.
- Channel 0 at 0x0000, delta 0xFF: value becomes 0xFFFF. With INPUT_ACCUM_CLAMP_EN at 0x7FFE, two deltas of +1: value is 0x7FFF.
- Mouse report with status=0x11 (X sign, left button), X=0xF0, Y=0x10: mouse_x=0xFFF0, mouse_y=0xFFF0, mouse_btn=3'b001, mouse_events=1.
- Event in the same cycle as vb_rise: the snapshot excludes it; the next vb_rise includes it.
- clear in the same cycle as an event and vb_rise: all outputs 0 and frame_strobe=1 the next cycle; the event is lost.
